// File: rtl/pc_branch_unit.sv
// pc_branch_unit: 16-bit {PCH,PCL} program counter with absolute load, increment and 8-bit relative branch.
// Define PC_BRANCH_PENALTY_EN to give page-crossing branches an extra FIX_HIGH cycle that adjusts PCH.
module pc_branch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_addr,
    input  logic        inc,
    input  logic        branch,
    input  logic        taken,
    input  logic [7:0]  offset,
    output logic [15:0] pc,
    output logic        busy,
    output logic        page_cross,
    output logic        done
);

    logic [7:0] pch_q, pch_d;
    logic [7:0] pcl_q, pcl_d;
    logic       page_cross_q, page_cross_d;
    logic       done_q, done_d;
    logic [8:0] pcl_sum;
    logic       back;
    logic       crossing;

    assign pcl_sum = {1'b0, pcl_q} + {1'b0, offset};
    assign back    = offset[7];
    // Forward with carry out, or backward without it, means PCH must move.
    assign crossing = back ^ pcl_sum[8];

`ifdef PC_BRANCH_PENALTY_EN
    typedef enum logic {IDLE = 1'b0, FIX_HIGH = 1'b1} state_t;
    state_t state_q, state_d;
    logic   dir_back_q, dir_back_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!load && branch && taken && crossing) state_d = FIX_HIGH;
            FIX_HIGH: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == FIX_HIGH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_back_q <= 1'b0;
        end else begin
            dir_back_q <= dir_back_d;
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        pch_d        = pch_q;
        pcl_d        = pcl_q;
        page_cross_d = page_cross_q;
        done_d       = 1'b0;
`ifdef PC_BRANCH_PENALTY_EN
        dir_back_d   = dir_back_q;
        if (state_q == FIX_HIGH) begin
            pch_d  = dir_back_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
            done_d = 1'b1;
        end else
`endif
        if (load) begin
            {pch_d, pcl_d} = load_addr;
            page_cross_d   = 1'b0;
        end else if (branch) begin
            if (!taken) begin
                page_cross_d = 1'b0;
                done_d       = 1'b1;
            end else begin
                pcl_d        = pcl_sum[7:0];
                page_cross_d = crossing;
`ifdef PC_BRANCH_PENALTY_EN
                dir_back_d   = back;
                done_d       = !crossing;
`else
                if (crossing) pch_d = back ? (pch_q - 8'd1) : (pch_q + 8'd1);
                done_d       = 1'b1;
`endif
            end
        end else if (inc) begin
            {pch_d, pcl_d} = {pch_q, pcl_q} + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pch_q        <= RESET_PC[15:8];
            pcl_q        <= RESET_PC[7:0];
            page_cross_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            pch_q        <= pch_d;
            pcl_q        <= pcl_d;
            page_cross_q <= page_cross_d;
            done_q       <= done_d;
        end
    end

    assign pc         = {pch_q, pcl_q};
    assign page_cross = page_cross_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios plus randomized traffic against a target-address model.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_addr = 16'h0;
    logic        inc = 1'b0;
    logic        branch = 1'b0;
    logic        taken = 1'b0;
    logic [7:0]  offset = 8'h0;
    logic [15:0] pc;
    logic        busy;
    logic        page_cross;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: final branch target is simply pc + sign-extended offset.
    logic [15:0] m_pc = 16'h0;
    logic [15:0] m_tgt = 16'h0;
    logic        m_busy = 1'b0;
    logic        m_pcx = 1'b0;
    logic        m_done = 1'b0;

    localparam logic [15:0] RST_PC = 16'hFFFC;

    pc_branch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_addr(load_addr), .inc(inc),
        .branch(branch), .taken(taken), .offset(offset), .pc(pc), .busy(busy),
        .page_cross(page_cross), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] obs();
        return {pc, busy, page_cross, done};
    endfunction

    task automatic model_update(input logic r, input logic l, input logic [15:0] la,
                                input logic i, input logic b, input logic t, input logic [7:0] off);
        logic [15:0] tgt;
        if (!r) begin
            m_pc = RST_PC; m_busy = 1'b0; m_pcx = 1'b0; m_done = 1'b0;
        end else if (m_busy) begin
            m_pc = m_tgt; m_busy = 1'b0; m_done = 1'b1;
        end else begin
            m_done = 1'b0;
            if (l) begin
                m_pc = la; m_pcx = 1'b0;
            end else if (b) begin
                if (!t) begin
                    m_pcx = 1'b0; m_done = 1'b1;
                end else begin
                    tgt   = m_pc + {{8{off[7]}}, off};
                    m_pcx = (tgt[15:8] != m_pc[15:8]);
`ifdef PC_BRANCH_PENALTY_EN
                    if (m_pcx) begin
                        m_pc   = {m_pc[15:8], tgt[7:0]};
                        m_tgt  = tgt;
                        m_busy = 1'b1;
                    end else begin
                        m_pc = tgt; m_done = 1'b1;
                    end
`else
                    m_pc = tgt; m_done = 1'b1;
`endif
                end
            end else if (i) begin
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] la,
                        input logic i, input logic b, input logic t, input logic [7:0] off);
        rst_n = r; load = l; load_addr = la; inc = i; branch = b; taken = t; offset = off;
        @(posedge clk);
        model_update(r, l, la, i, b, t, off);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    endtask

    task automatic do_load(input logic [15:0] a);
        step(1'b1, 1'b1, a, 1'b0, 1'b0, 1'b0, 8'h0);
    endtask

    task automatic do_branch(input logic t, input logic [7:0] off);
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, t, off);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 8'h33);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        n_checks++;
        if (obs() !== {RST_PC, 3'b000}) begin
            n_fail++; $display("FAIL reset {pc,busy,pcx,done} got=%h exp=%h", obs(), {RST_PC, 3'b000});
        end
    endtask

    task automatic test_inc_wrap();
        logic [15:0] exp_pc [4];
        exp_pc = '{16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'h0);
            n_checks++;
            if (obs() !== {exp_pc[k], 3'b000}) begin
                n_fail++; $display("FAIL inc_wrap[%0d] got=%h exp=%h", k, obs(), {exp_pc[k], 3'b000});
            end
        end
    endtask

    task automatic test_no_cross();
        do_load(16'h12F0);
        do_branch(1'b1, 8'h05);
        n_checks++;
        if (obs() !== {16'h12F5, 3'b001}) begin
            n_fail++; $display("FAIL no_cross got=%h exp=%h", obs(), {16'h12F5, 3'b001});
        end
        idle();
        n_checks++;
        if (obs() !== {16'h12F5, 3'b000}) begin
            n_fail++; $display("FAIL no_cross_done_pulse got=%h exp=%h", obs(), {16'h12F5, 3'b000});
        end
        do_branch(1'b1, 8'h00);
        n_checks++;
        if (obs() !== {16'h12F5, 3'b001}) begin
            n_fail++; $display("FAIL zero_offset got=%h exp=%h", obs(), {16'h12F5, 3'b001});
        end
    endtask

    task automatic test_fwd_cross();
        do_load(16'h12F0);
        do_branch(1'b1, 8'h20);
`ifdef PC_BRANCH_PENALTY_EN
        n_checks++;
        if (obs() !== {16'h1210, 3'b110}) begin
            n_fail++; $display("FAIL fwd_cross_fix got=%h exp=%h", obs(), {16'h1210, 3'b110});
        end
        idle();
`endif
        n_checks++;
        if (obs() !== {16'h1310, 3'b011}) begin
            n_fail++; $display("FAIL fwd_cross_end got=%h exp=%h", obs(), {16'h1310, 3'b011});
        end
        idle();
        n_checks++;
        if (obs() !== {16'h1310, 3'b010}) begin
            n_fail++; $display("FAIL fwd_cross_after got=%h exp=%h", obs(), {16'h1310, 3'b010});
        end
    endtask

    task automatic test_back_cross();
        do_load(16'h1205);
        do_branch(1'b1, 8'hF0);
`ifdef PC_BRANCH_PENALTY_EN
        n_checks++;
        if (obs() !== {16'h12F5, 3'b110}) begin
            n_fail++; $display("FAIL back_cross_fix got=%h exp=%h", obs(), {16'h12F5, 3'b110});
        end
        idle();
`endif
        n_checks++;
        if (obs() !== {16'h11F5, 3'b011}) begin
            n_fail++; $display("FAIL back_cross_end got=%h exp=%h", obs(), {16'h11F5, 3'b011});
        end
        do_branch(1'b0, 8'h40);
        n_checks++;
        if (obs() !== {16'h11F5, 3'b001}) begin
            n_fail++; $display("FAIL not_taken got=%h exp=%h", obs(), {16'h11F5, 3'b001});
        end
    endtask

    task automatic test_pch_wrap();
        do_load(16'h0005);
        do_branch(1'b1, 8'hF0);
`ifdef PC_BRANCH_PENALTY_EN
        idle();
`endif
        n_checks++;
        if (obs() !== {16'hFFF5, 3'b011}) begin
            n_fail++; $display("FAIL pch_wrap_down got=%h exp=%h", obs(), {16'hFFF5, 3'b011});
        end
        do_load(16'hFFF0);
        do_branch(1'b1, 8'h20);
`ifdef PC_BRANCH_PENALTY_EN
        idle();
`endif
        n_checks++;
        if (obs() !== {16'h0010, 3'b011}) begin
            n_fail++; $display("FAIL pch_wrap_up got=%h exp=%h", obs(), {16'h0010, 3'b011});
        end
    endtask

    task automatic test_priority();
        do_load(16'h2000);
        step(1'b1, 1'b1, 16'hC000, 1'b1, 1'b1, 1'b1, 8'h7F);
        n_checks++;
        if (obs() !== {16'hC000, 3'b000}) begin
            n_fail++; $display("FAIL priority got=%h exp=%h", obs(), {16'hC000, 3'b000});
        end
        do_load(16'h12F0);
        do_branch(1'b1, 8'h20);
        step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h01);
`ifdef PC_BRANCH_PENALTY_EN
        n_checks++;
        if (obs() !== {16'h1310, 3'b011}) begin
            n_fail++; $display("FAIL fix_ignores_req got=%h exp=%h", obs(), {16'h1310, 3'b011});
        end
`else
        n_checks++;
        if (obs() !== {16'h0000, 3'b000}) begin
            n_fail++; $display("FAIL load_after_branch got=%h exp=%h", obs(), {16'h0000, 3'b000});
        end
`endif
    endtask

    task automatic test_reset_mid_fix();
        do_load(16'hFFF0);
        do_branch(1'b1, 8'h20);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        n_checks++;
        if (obs() !== {RST_PC, 3'b000}) begin
            n_fail++; $display("FAIL reset_mid_fix got=%h exp=%h", obs(), {RST_PC, 3'b000});
        end
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        n_checks++;
        if (obs() !== {16'hFFFD, 3'b000}) begin
            n_fail++; $display("FAIL first_after_reset got=%h exp=%h", obs(), {16'hFFFD, 3'b000});
        end
    endtask

    task automatic test_random();
        logic r, l, i, b, t;
        logic [15:0] la;
        logic [7:0] off;
        for (int k = 0; k < 600; k++) begin
            r   = ($urandom_range(0, 49) != 0);
            l   = ($urandom_range(0, 7) == 0);
            i   = ($urandom_range(0, 2) == 0);
            b   = ($urandom_range(0, 1) == 0);
            t   = ($urandom_range(0, 3) != 0);
            la  = 16'($urandom);
            off = 8'($urandom);
            step(r, l, la, i, b, t, off);
            n_checks++;
            if (obs() !== {m_pc, m_busy, m_pcx, m_done}) begin
                n_fail++;
                $display("FAIL random[%0d] {pc,busy,pcx,done} got=%h exp=%h", k, obs(),
                         {m_pc, m_busy, m_pcx, m_done});
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_no_cross();
        test_fwd_cross();
        test_back_cross();
        test_pch_wrap();
        test_priority();
        test_reset_mid_fix();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_unit.md
PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 load  input  1  SHALL request an absolute PC load from load_addr.
REQ-005 load_addr  input  16  SHALL be the absolute target, sampled when load is accepted.
REQ-006 inc  input  1  SHALL request PC+1 with 16-bit wrap.
REQ-007 branch  input  1  SHALL request a relative branch.
REQ-008 taken  input  1  SHALL qualify branch; 0 means the condition failed.
REQ-009 offset  input  8  SHALL be the two's-complement branch displacement, -128..+127.
REQ-010 pc  output  16  SHALL be the registered program counter, {PCH, PCL}.
REQ-011 busy  output  1  SHALL be high, combinationally, while state is FIX_HIGH.
REQ-012 page_cross  output  1  SHALL be high when the last taken branch changed PCH; it is registered.
REQ-013 done  output  1  SHALL be a one-cycle registered pulse on the cycle after a branch completes.

Function
REQ-014 States SHALL be IDLE and FIX_HIGH only.
REQ-015 In IDLE, request priority SHALL be load > branch > inc; lower-priority requests in the same cycle are dropped.
REQ-016 Accepted load SHALL set pc <= load_addr, clear page_cross, and leave done low.
REQ-017 Accepted inc SHALL set pc <= pc+1; carry from PCL into PCH is applied in the same edge; FFFF wraps to 0000.
REQ-018 Branch with taken=0 SHALL leave pc unchanged, clear page_cross, pulse done next cycle.
REQ-019 Taken branch SHALL set PCL <= PCL + offset (8-bit, low carry c captured) at the accepting edge.
REQ-020 Page cross SHALL be defined as: offset[7]=0 and c=1 (forward, PCH+1), or offset[7]=1 and c=0 (backward, PCH-1).
REQ-021 No page cross: state stays IDLE, page_cross <= 0, done pulses next cycle (1-cycle branch).
REQ-022 Page cross: state <= FIX_HIGH, page_cross <= 1, direction latched; next edge PCH <= PCH±1 (8-bit wrap), state <= IDLE, done pulses.
REQ-023 In FIX_HIGH, load/branch/inc SHALL be ignored, not queued; pc shows the intermediate {old PCH, new PCL}.
REQ-024 PCH wrap SHALL be modular: FF+1 -> 00, 00-1 -> FF.
REQ-025 Offset 0 taken SHALL behave as no-cross taken branch (pc unchanged, done pulses).

Reset
REQ-026 With rst_n low at a rising edge: pc <= RESET_PC, state <= IDLE, page_cross <= 0, done <= 0; busy therefore 0.
REQ-027 Reset SHALL override any request and abort FIX_HIGH mid-operation with no PCH fixup applied.
REQ-028 The first request accepted is the one present on the first edge with rst_n high.

Configuration
REQ-029 Macro PC_BRANCH_PENALTY_EN defined: page-crossing branches take the two-cycle FIX_HIGH path of REQ-022.
REQ-030 Macro undefined: FIX_HIGH is not built; PCH±1 is applied at the same edge as PCL, busy is tied 0, page_cross still reports the crossing, done pulses next cycle.

Verification
REQ-031 Reset with RESET_PC=16'hFFFC, release, inc x4 -> pc FFFD, FFFE, FFFF, 0000; page_cross 0, done never high.
REQ-032 pc=0x12F0, taken branch offset 0x05 -> pc 0x12F5 next cycle, page_cross 0, done 1 for one cycle, busy never high.
REQ-033 pc=0x12F0, taken branch offset 0x20 (PENALTY_EN) -> cycle+1 pc 0x1210 busy 1 page_cross 1; cycle+2 pc 0x1310 busy 0 done 1.
REQ-034 pc=0x1205, taken branch offset 0xF0 (-16) -> 0x12F5 then 0x11F5; macro off -> 0x11F5 in one cycle, busy 0, page_cross 1.
REQ-035 pc=0x2000, load=1 branch=1 inc=1 with load_addr 0xC000 -> pc 0xC000, done 0; inc during FIX_HIGH ignored, pc unchanged by it.
REQ-036 pc=0xFFF0 taken offset 0x20 then rst_n low during FIX_HIGH -> pc RESET_PC, busy 0, page_cross 0, done 0.
